capture_readback: RTL

CAPTURE_READBACK -- requirements
Module: capture_readback

---
 rtl/capture_readback.sv | 125 ++++++++++++
 1 files changed

// File: rtl/capture_readback.sv
// Readback engine: streams COUNT words out of a synchronous sample buffer.
// Reads run ahead of the consumer by at most two words, held in a 2-entry skid FIFO.
module capture_readback #(
    parameter int DEPTH = 6144
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        START,
    input  logic [12:0] START_ADDR,
    input  logic [12:0] COUNT,
    output logic [12:0] RAM_ADDR,
    output logic        RAM_EN,
    output logic        RAM_WE,
    input  logic [7:0]  RAM_DOUT,
    input  logic        RAM_DOUTP,
    output logic [8:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [13:0] DEPTH_W   = 14'(DEPTH);
    localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state, state_next;
    logic [12:0] addr;
    logic [13:0] len;
    logic [13:0] issued;
    logic [13:0] delivered;
    logic        in_flight;
    logic [8:0]  fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  occ;
    logic        done_r;
    logic        issue;
    logic        pop;
    logic [1:0]  slots_used;

    // A word leaving this cycle frees its slot now, which keeps the stream at one word per cycle.
    always_comb begin
        pop        = (occ != 2'd0) && OUT_READY;
        slots_used = occ + {1'b0, in_flight} - {1'b0, pop};
        issue      = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (START && COUNT != 13'd0) state_next = RUN;
            end
            RUN: begin
                issue = (issued < len) && (slots_used < 2'd2);
                if (issue && issued == len - 14'd1) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && delivered == len - 14'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state       <= IDLE;
            addr        <= '0;
            len         <= '0;
            issued      <= '0;
            delivered   <= '0;
            in_flight   <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= '0;
            done_r      <= 1'b0;
            // NOTE: the two FIFO words are reset too, so OUT_DATA reads 0 after reset.
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every update here sees pre-edge values.
            state     <= state_next;
            done_r    <= 1'b0;
            in_flight <= issue;

            if (state == IDLE && START) begin
                if (COUNT == 13'd0) begin
                    done_r <= 1'b1;
                end else begin
                    addr      <= ({1'b0, START_ADDR} >= DEPTH_W) ? 13'd0 : START_ADDR;
                    len       <= ({1'b0, COUNT} > DEPTH_W) ? DEPTH_W : {1'b0, COUNT};
                    issued    <= '0;
                    delivered <= '0;
                end
            end

            if (issue) begin
                addr   <= (addr == LAST_ADDR) ? 13'd0 : addr + 13'd1;
                issued <= issued + 14'd1;
            end

            if (pop) delivered <= delivered + 14'd1;

            if (state == DRAIN && state_next == IDLE) done_r <= 1'b1;

            if (in_flight) begin
                fifo_mem[wr_ptr] <= {RAM_DOUTP, RAM_DOUT};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    assign RAM_EN    = issue;
    assign RAM_ADDR  = addr;
    assign RAM_WE    = 1'b0;
    assign OUT_VALID = (occ != 2'd0);
    assign OUT_DATA  = fifo_mem[rd_ptr];
    assign BUSY      = (state != IDLE);
    assign DONE      = done_r;

endmodule
